// File: rtl/demux18_collect.sv
// ---------------------------------------------------------------------------
// demux18_collect
//
// Registered 1:8 demultiplexer / collector. Each accepted word is steered into
// one of eight holding registers (a..h). The target is either the explicit
// channel select or an internal round-robin slot pointer. The block records
// which channels have been written in the current frame and pulses frame_done
// once all eight are filled. The holding registers can then feed an 8:1 mux
// for readback.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   flush          synchronous frame abort (flags/slot/error cleared, data kept)
//   in_valid       write strobe for in_data
//   in_data[W-1:0] word to store
//   sel[2:0]       target channel when mode = 0 (0 -> a ... 7 -> h)
//   mode           0 = addressed by sel, 1 = round-robin by slot
//   a..h[W-1:0]    holding registers for channels 0..7
//   ch_valid[7:0]  per-channel "written this frame" flags, bit i = channel i
//   slot[2:0]      current round-robin pointer
//   frame_done     one-cycle pulse when the frame completes
//   overwrite_err  sticky: a channel was written twice within one frame
// ---------------------------------------------------------------------------
module demux18_collect #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [2:0]   sel,
    input  logic         mode,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [W-1:0] e,
    output logic [W-1:0] f,
    output logic [W-1:0] g,
    output logic [W-1:0] h,
    output logic [7:0]   ch_valid,
    output logic [2:0]   slot,
    output logic         frame_done,
    output logic         overwrite_err
);

    logic [W-1:0] regs [8];

    logic [2:0] tgt;       // channel addressed this cycle
    logic [7:0] tgt_oh;    // one-hot of tgt
    logic [7:0] base_cv;   // flags the current write builds on
    logic [7:0] nxt_cv;    // flags after this cycle's write

    // NOTE: every always_comb output gets a value on every path (here
    // unconditionally), so no latch can be inferred.
    always_comb begin
        tgt    = mode ? slot : sel;
        tgt_oh = 8'b1 << tgt;
        // While frame_done is high, ch_valid shows the completed frame (FF);
        // the next frame starts from empty so back-to-back frames need no
        // dead cycle.
        base_cv = frame_done ? 8'h00 : ch_valid;
        nxt_cv  = base_cv | tgt_oh;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding registers are reset because their reset value
            // is architecturally visible on a..h, unlike a plain storage array.
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            ch_valid      <= 8'h00;
            slot          <= 3'd0;
            frame_done    <= 1'b0;
            overwrite_err <= 1'b0;
        end else if (flush) begin
            // Abort the frame; data registers are deliberately kept and any
            // concurrent write is dropped.
            ch_valid      <= 8'h00;
            slot          <= 3'd0;
            frame_done    <= 1'b0;
            overwrite_err <= 1'b0;
        end else if (in_valid) begin
            regs[tgt] <= in_data;
            if (mode) begin
                slot <= slot + 3'd1;   // wraps 7 -> 0 naturally
            end
            if (base_cv[tgt]) begin
                overwrite_err <= 1'b1;
            end
            if (nxt_cv == 8'hFF) begin
                frame_done <= 1'b1;
                ch_valid   <= 8'hFF;
            end else begin
                frame_done <= 1'b0;
                ch_valid   <= nxt_cv;
            end
        end else begin
            frame_done <= 1'b0;
            ch_valid   <= base_cv;   // performs the post-frame clear
        end
    end

    assign a = regs[0];
    assign b = regs[1];
    assign c = regs[2];
    assign d = regs[3];
    assign e = regs[4];
    assign f = regs[5];
    assign g = regs[6];
    assign h = regs[7];

endmodule
